// File: rtl/bcp_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcp_scheduler_pkg
// Description : Shared widths, imply-stack literal types and scheduler state
//               encoding for the BCP clause scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package bcp_scheduler_pkg;

  // Default index widths used across the solver datapath
  localparam int MAX_CLAUSES_BITS = 8;
  localparam int MAX_VARS_BITS    = 8;

  // Literal origin tags written to the imply stack alongside each entry
  localparam logic IMPLY_TYPE_IMPLIED = 1'b0;
  localparam logic IMPLY_TYPE_DECIDED = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    PUSH  = 3'd3,
    DONE  = 3'd4
  } bcp_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/bcp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bcp_scheduler
// Description : Walks the clause range watched by a newly assigned variable,
//               issuing one clause at a time to the BCP evaluator, pushing unit
//               implications and stopping on the first conflict.
// Revision    : 1.0 - initial release
// ============================================================================
module bcp_scheduler
  import bcp_scheduler_pkg::*;
#(
  parameter int CLAUSE_BITS = MAX_CLAUSES_BITS,
  parameter int VAR_BITS    = MAX_VARS_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [VAR_BITS-1:0]    var_in,
  input  logic                   val_in,
  input  logic [CLAUSE_BITS-1:0] start_clause,
  input  logic [CLAUSE_BITS-1:0] end_clause,
  output logic                   busy,
  output logic                   done,
  output logic                   conflict,
  output logic [CLAUSE_BITS-1:0] conflict_clause_idx,
  output logic                   eval_valid,
  output logic [CLAUSE_BITS-1:0] eval_clause_idx,
  output logic [VAR_BITS-1:0]    eval_var,
  output logic                   eval_val,
  input  logic                   eval_ready,
  input  logic                   res_valid,
  input  logic                   res_conflict,
  input  logic                   res_unit,
  input  logic [VAR_BITS-1:0]    res_var,
  input  logic                   res_val,
  output logic                   push_imply,
  output logic [VAR_BITS-1:0]    var_in_imply,
  output logic                   val_in_imply,
  output logic                   type_in_imply,
  input  logic                   full_imply
);

  bcp_sched_state_t       state_q;
  logic [CLAUSE_BITS-1:0] cur_q;
  logic [CLAUSE_BITS-1:0] end_q;
  logic [CLAUSE_BITS-1:0] cur_d;
  logic                   last_d;
  logic                   busy_q;
  logic                   done_q;
  logic                   conflict_q;
  logic [CLAUSE_BITS-1:0] conflict_idx_q;
  logic                   eval_valid_q;
  logic [CLAUSE_BITS-1:0] eval_idx_q;
  logic [VAR_BITS-1:0]    eval_var_q;
  logic                   eval_val_q;
  logic                   push_q;
  logic [VAR_BITS-1:0]    imply_var_q;
  logic                   imply_val_q;

  // Compare-before-increment: the last index is detected before cur_q moves,
  // so a range ending at the top code never wraps.
  assign cur_d  = cur_q + {{(CLAUSE_BITS-1){1'b0}}, 1'b1};
  assign last_d = (cur_q == end_q);

  // Scheduler FSM with all handshake and status outputs registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      cur_q          <= '0;
      end_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_idx_q <= '0;
      eval_valid_q   <= 1'b0;
      eval_idx_q     <= '0;
      eval_var_q     <= '0;
      eval_val_q     <= 1'b0;
      push_q         <= 1'b0;
      imply_var_q    <= '0;
      imply_val_q    <= 1'b0;
    end else if (abort) begin
      // Cancel silently: no done pulse, outstanding request and push dropped
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      eval_valid_q <= 1'b0;
      push_q       <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      push_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            eval_var_q <= var_in;
            eval_val_q <= val_in;
            end_q      <= end_clause;
            cur_q      <= start_clause;
            conflict_q <= 1'b0;
            busy_q     <= 1'b1;
            if (start_clause > end_clause) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              eval_valid_q <= 1'b1;
              eval_idx_q   <= start_clause;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (eval_ready) begin
            eval_valid_q <= 1'b0;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (res_valid) begin
            if (res_conflict) begin
              conflict_q     <= 1'b1;
              conflict_idx_q <= cur_q;
              done_q         <= 1'b1;
              state_q        <= DONE;
            end else if (res_unit) begin
              imply_var_q <= res_var;
              imply_val_q <= res_val;
              state_q     <= PUSH;
            end else if (last_d) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cur_q        <= cur_d;
              eval_valid_q <= 1'b1;
              eval_idx_q   <= cur_d;
              state_q      <= ISSUE;
            end
          end
        end
        PUSH: begin
          // Hold the captured literal until the imply stack has room
          if (!full_imply) begin
            push_q <= 1'b1;
            if (last_d) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cur_q        <= cur_d;
              eval_valid_q <= 1'b1;
              eval_idx_q   <= cur_d;
              state_q      <= ISSUE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q       <= 1'b0;
          eval_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign conflict            = conflict_q;
  assign conflict_clause_idx = conflict_idx_q;
  assign eval_valid          = eval_valid_q;
  assign eval_clause_idx     = eval_idx_q;
  assign eval_var            = eval_var_q;
  assign eval_val            = eval_val_q;
  assign push_imply          = push_q;
  assign var_in_imply        = imply_var_q;
  assign val_in_imply        = imply_val_q;
  assign type_in_imply       = IMPLY_TYPE_IMPLIED;

endmodule
`default_nettype wire

// File: tb/tb_bcp_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bcp_scheduler
// Description : Directed scoreboard bench for bcp_scheduler with a small
//               evaluator/imply-stack responder driven from the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcp_scheduler;
  import bcp_scheduler_pkg::*;

  localparam int CB = 4;
  localparam int VB = 5;

  logic          clock = 1'b0;
  logic          reset, start, abort, val_in;
  logic [VB-1:0] var_in, res_var;
  logic [CB-1:0] start_clause, end_clause;
  logic          busy, done, conflict, eval_valid, eval_val, eval_ready;
  logic [CB-1:0] conflict_clause_idx, eval_clause_idx;
  logic [VB-1:0] eval_var, var_in_imply;
  logic          res_valid, res_conflict, res_unit, res_val;
  logic          push_imply, val_in_imply, type_in_imply, full_imply;

  int checks = 0;
  int errors = 0;
  int exp_req[$];
  int exp_push[$];

  bcp_scheduler #(.CLAUSE_BITS(CB), .VAR_BITS(VB)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .var_in(var_in), .val_in(val_in),
    .start_clause(start_clause), .end_clause(end_clause),
    .busy(busy), .done(done), .conflict(conflict),
    .conflict_clause_idx(conflict_clause_idx),
    .eval_valid(eval_valid), .eval_clause_idx(eval_clause_idx),
    .eval_var(eval_var), .eval_val(eval_val), .eval_ready(eval_ready),
    .res_valid(res_valid), .res_conflict(res_conflict), .res_unit(res_unit),
    .res_var(res_var), .res_val(res_val),
    .push_imply(push_imply), .var_in_imply(var_in_imply),
    .val_in_imply(val_in_imply), .type_in_imply(type_in_imply),
    .full_imply(full_imply)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start one range and service the evaluator / imply stack until done.
  task automatic run_range(
    input int sc, input int ec, input int vin, input int vval,
    input int unit_idx, input int uvar, input int uval, input int conf_idx,
    input int full_cycles, input int ready_low,
    input int exp_done_cyc, input int exp_busy_cnt,
    input int exp_conf, input int exp_conf_idx);
    int cyc = 0;
    int pend = -1;
    int full_left = 0;
    int drop_cyc = -10;
    int ready_left = ready_low;
    int held = -1;
    int busy_cnt = 0;
    int e;
    bit got_done = 0;
    @(negedge clock);
    start = 1'b1; start_clause = CB'(sc); end_clause = CB'(ec);
    var_in = VB'(vin); val_in = vval[0];
    while (!got_done && cyc < 300) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      if (cyc == 1) check("conflict_clr_on_start", 32'(conflict), 0);
      if (busy) busy_cnt++;
      if (push_imply) begin
        check("push_expected", 32'(exp_push.size() > 0), 1);
        if (exp_push.size() > 0) begin
          e = exp_push.pop_front();
          check("push_var", 32'(var_in_imply), e % 256);
          check("push_val", 32'(val_in_imply), e / 256);
          check("push_type", 32'(type_in_imply), 32'(IMPLY_TYPE_IMPLIED));
        end
        if (full_cycles > 0) check("push_after_full", cyc, drop_cyc + 1);
      end
      if (done) begin
        got_done = 1;
        check("busy_at_done", 32'(busy), 1);
        check("conflict", 32'(conflict), exp_conf);
        if (exp_conf != 0) check("conflict_idx", 32'(conflict_clause_idx), exp_conf_idx);
        if (exp_done_cyc >= 0) check("done_latency", cyc, exp_done_cyc);
      end
      if (full_left > 0) begin
        full_left--;
        if (full_left == 0) begin
          full_imply = 1'b0;
          drop_cyc = cyc;
        end
      end
      res_valid = 1'b0; res_conflict = 1'b0; res_unit = 1'b0;
      if (pend >= 0) begin
        res_valid = 1'b1;
        res_conflict = (pend == conf_idx);
        res_unit = (pend == unit_idx);
        res_var = VB'(uvar); res_val = uval[0];
        if (res_unit && !res_conflict && full_cycles > 0) begin
          full_imply = 1'b1;
          full_left = full_cycles;
        end
        pend = -1;
      end
      eval_ready = 1'b0;
      if (eval_valid) begin
        if (held >= 0) check("idx_stable", 32'(eval_clause_idx), held);
        if (ready_left > 0) begin
          if (held < 0) held = int'(eval_clause_idx);
          ready_left--;
        end else begin
          eval_ready = 1'b1;
          held = -1;
          check("req_expected", 32'(exp_req.size() > 0), 1);
          if (exp_req.size() > 0) check("req_idx", 32'(eval_clause_idx), exp_req.pop_front());
          check("eval_var", 32'(eval_var), vin);
          check("eval_val", 32'(eval_val), vval);
          pend = int'(eval_clause_idx);
        end
      end
    end
    check("done_seen", 32'(got_done), 1);
    if (exp_busy_cnt >= 0) check("busy_cycles", busy_cnt, exp_busy_cnt);
    res_valid = 1'b0; res_conflict = 1'b0; res_unit = 1'b0; eval_ready = 1'b0;
    full_imply = 1'b0;
    @(negedge clock);
    check("done_one_pulse", 32'(done), 0);
    check("busy_after_done", 32'(busy), 0);
    check("all_req_seen", exp_req.size(), 0);
    check("all_push_seen", exp_push.size(), 0);
    exp_req.delete();
    exp_push.delete();
  endtask

  // Issue clause 10, abort while waiting for its result, then feed a late result.
  task automatic abort_seq(input int ready_low);
    int cyc = 0;
    int held = -1;
    int ready_left = ready_low;
    bit hs = 0;
    exp_req.push_back(10);
    @(negedge clock);
    start = 1'b1; start_clause = CB'(10); end_clause = CB'(12);
    var_in = VB'(3); val_in = 1'b0;
    while (!hs && cyc < 50) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      eval_ready = 1'b0;
      if (eval_valid) begin
        if (held >= 0) check("abort_idx_stable", 32'(eval_clause_idx), held);
        if (ready_left > 0) begin
          if (held < 0) held = int'(eval_clause_idx);
          ready_left--;
        end else begin
          eval_ready = 1'b1;
          hs = 1;
          check("abort_req_idx", 32'(eval_clause_idx), exp_req.pop_front());
        end
      end
    end
    check("abort_handshake_seen", 32'(hs), 1);
    @(negedge clock);
    eval_ready = 1'b0;
    check("wait_no_valid", 32'(eval_valid), 0);
    check("wait_busy", 32'(busy), 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_idle_busy", 32'(busy), 0);
    check("abort_no_done", 32'(done), 0);
    check("abort_no_valid", 32'(eval_valid), 0);
    res_valid = 1'b1; res_unit = 1'b1; res_conflict = 1'b0;
    res_var = VB'(9); res_val = 1'b1;
    @(negedge clock);
    res_valid = 1'b0; res_unit = 1'b0;
    repeat (3) begin
      check("late_no_push", 32'(push_imply), 0);
      check("late_no_done", 32'(done), 0);
      check("late_idle", 32'(busy), 0);
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; val_in = 1'b0; var_in = '0;
    start_clause = '0; end_clause = '0; eval_ready = 1'b0;
    res_valid = 1'b0; res_conflict = 1'b0; res_unit = 1'b0;
    res_var = '0; res_val = 1'b0; full_imply = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_conflict", 32'(conflict), 0);
    check("rst_conflict_idx", 32'(conflict_clause_idx), 0);
    check("rst_eval_valid", 32'(eval_valid), 0);
    check("rst_eval_idx", 32'(eval_clause_idx), 0);
    check("rst_eval_var", 32'(eval_var), 0);
    check("rst_eval_val", 32'(eval_val), 0);
    check("rst_push", 32'(push_imply), 0);
    check("rst_imply_var", 32'(var_in_imply), 0);
    check("rst_imply_val", 32'(val_in_imply), 0);
    check("rst_imply_type", 32'(type_in_imply), 0);
    reset = 1'b0;

    // Plain range, no units, no conflicts
    exp_req.push_back(4); exp_req.push_back(5); exp_req.push_back(6);
    run_range(4, 6, 2, 1, -1, 0, 0, -1, 0, 0, -1, -1, 0, 0);

    // Clause 3 is unit: var 7 = 1
    exp_req.push_back(2); exp_req.push_back(3); exp_req.push_back(4);
    exp_push.push_back(1 * 256 + 7);
    run_range(2, 4, 1, 0, 3, 7, 1, -1, 0, 0, -1, -1, 0, 0);

    // Clause 5 conflicts: nothing past 5 is requested
    for (int i = 0; i <= 5; i++) exp_req.push_back(i);
    run_range(0, 9, 6, 1, -1, 0, 0, 5, 0, 0, -1, -1, 1, 5);
    repeat (3) begin
      check("conflict_held", 32'(conflict), 1);
      check("conflict_idx_held", 32'(conflict_clause_idx), 5);
      @(negedge clock);
    end

    // Empty range: done one cycle after start, busy for one cycle
    run_range(8, 3, 4, 0, -1, 0, 0, -1, 0, 0, 1, 1, 0, 0);

    // Stack full for 4 cycles on a unit at 14; range ends at the top index
    exp_req.push_back(13); exp_req.push_back(14); exp_req.push_back(15);
    exp_push.push_back(0 * 256 + 4);
    run_range(13, 15, 5, 1, 14, 4, 0, -1, 4, 0, -1, -1, 0, 0);

    // Abort in WAIT, late result ignored, then a normal range
    abort_seq(0);
    exp_req.push_back(1); exp_req.push_back(2);
    run_range(1, 2, 8, 0, -1, 0, 0, -1, 0, 0, -1, -1, 0, 0);

    // Same with the evaluator stalling the first request for 3 cycles
    abort_seq(3);
    exp_req.push_back(1); exp_req.push_back(2);
    run_range(1, 2, 9, 1, -1, 0, 0, -1, 0, 3, -1, -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcp_scheduler.md
Name: bcp_scheduler

Overview:
Sequences clause evaluation for one newly assigned variable. Walks the clause-index range that the var start/end table returns and issues each index to the BCP clause evaluator, one request outstanding at a time. Pushes unit implications onto the imply stack and aborts on the first conflict. Sits between the top-level control FSM and the BCP core; control starts it and waits for done.

Parameters:
CLAUSE_BITS, `MAX_CLAUSES_BITS, width of clause indices
VAR_BITS, `MAX_VARS_BITS, width of variable ids

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request from control; sampled only in IDLE
abort  input  1  synchronous cancel (control's reset_bcp); dominates all but reset
var_in  input  VAR_BITS  variable just assigned
val_in  input  1  value assigned to var_in
start_clause  input  CLAUSE_BITS  first clause index, inclusive
end_clause  input  CLAUSE_BITS  last clause index, inclusive; start_clause > end_clause means empty
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the range is finished or a conflict is found
conflict  output  1  set with done on conflict; held until next accepted start, abort or reset
conflict_clause_idx  output  CLAUSE_BITS  index of the conflicting clause; valid while conflict=1
eval_valid  output  1  clause request to evaluator
eval_clause_idx  output  CLAUSE_BITS  clause index being requested
eval_var  output  VAR_BITS  latched var_in, forwarded with request
eval_val  output  1  latched val_in
eval_ready  input  1  evaluator accepts request when eval_valid & eval_ready
res_valid  input  1  evaluator result strobe, one cycle
res_conflict  input  1  clause is falsified
res_unit  input  1  clause is unit; res_var/res_val give the implied literal
res_var  input  VAR_BITS  implied variable
res_val  input  1  implied value
push_imply  output  1  one-cycle push to imply stack
var_in_imply  output  VAR_BITS  implied variable
val_in_imply  output  1  implied value
type_in_imply  output  1  always IMPLY_TYPE_IMPLIED (0)
full_imply  input  1  imply stack full; push is withheld while high

Behaviour:
- Reset: state=IDLE. All outputs 0: busy, done, conflict, conflict_clause_idx, eval_*, push_imply, var_in_imply, val_in_imply, type_in_imply.
- IDLE: when start=1, latch var_in, val_in and end_clause, and set cur=start_clause. If start_clause > end_clause, go to DONE; otherwise go to ISSUE. Accepting start clears conflict. A start received in any other state is ignored.
- ISSUE: eval_valid=1 and eval_clause_idx=cur, both held stable until eval_ready. The cycle with eval_valid & eval_ready is the handshake; the next state is WAIT.
- WAIT: eval_valid=0. Stay in WAIT until res_valid.
  - If res_conflict=1, set conflict=1, capture conflict_clause_idx=cur and go to DONE. Conflict wins when res_conflict and res_unit are both high.
  - Else if res_unit=1, capture res_var/res_val and go to PUSH.
  - Else run ADVANCE.
- PUSH: when full_imply=0, drive push_imply=1 for exactly one cycle with the captured literal, then run ADVANCE. When full_imply=1, stall in PUSH with push_imply=0. No overflow flag.
- ADVANCE (a transition, not a state): if cur==end_clause, go to DONE; else cur<=cur+1 and go to ISSUE. Because the compare happens before the increment, end_clause = 2^CLAUSE_BITS-1 works and cur never wraps.
- DONE: done=1 for one cycle, then IDLE. busy is still 1 in DONE and falls in the following cycle.
- Minimum latency per clause: ISSUE 1 cycle plus WAIT of at least 1 cycle, plus 1 cycle in PUSH for a unit clause.
- abort=1 in any state: next state is IDLE, and in that same posedge clear eval_valid, push_imply and conflict. No done pulse. A res_valid arriving after an abort is ignored because the block is in IDLE.
- reset has priority over abort, and abort over start.

Decomposition:
- sysdefs.svh gains:
  - typedef enum bcp_sched_state_t {IDLE, ISSUE, WAIT, PUSH, DONE}
  - IMPLY_TYPE_IMPLIED=1'b0 and IMPLY_TYPE_DECIDED=1'b1, shared with control and the trace stack
- Reuse the existing `MAX_CLAUSES_BITS and `MAX_VARS_BITS.
- No sub-module. It is a single FSM plus an index register and capture registers, kept flat.

Test Plan:
- Range 4..6, evaluator ready=1 and replies one cycle later with no unit/conflict: requests for indices 4,5,6 in order, done pulses once, conflict=0, push_imply never asserted.
- Range 2..4, clause 3 returns res_unit with var 7, val 1: exactly one push_imply with var_in_imply=7, val_in_imply=1, type=0; done after clause 4.
- Range 0..9, clause 5 returns res_conflict: no request for index 6; done with conflict=1, conflict_clause_idx=5; conflict stays 1 until the next start.
- start_clause=8, end_clause=3: no eval_valid; done asserted 1 cycle after start; busy high for exactly 1 cycle.
- full_imply held high for 4 cycles on a unit result: block stalls in PUSH with no push; a single push follows the cycle after full_imply drops. Range end at 2^CLAUSE_BITS-1 finishes without wrapping.
- abort asserted in WAIT, then a late res_valid, then a new start: no done, no push from the late result; IDLE the cycle after abort; the new range runs normally. Same sequence with eval_ready low for 3 cycles holds eval_clause_idx stable throughout.
